// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with 1-cycle divide special cases.
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [2:0]       i_func3,
   input  logic [WIDTH-1:0] i_rs1,
   input  logic [WIDTH-1:0] i_rs2,
   input  logic             i_flush,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic               hi_q, hi_d;
   logic               fast_q, fast_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;

   function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
      return n ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] mul_fix(input logic [2*WIDTH-1:0] acc,
                                                input logic n, input logic hi);
      logic [2*WIDTH-1:0] full;
      full = n ? -acc : acc;
      return hi ? full[2*WIDTH-1:WIDTH] : full[WIDTH-1:0];
   endfunction

   // Divide accumulator holds {remainder, quotient}; hi selects the remainder.
   function automatic logic [WIDTH-1:0] div_fix(input logic [2*WIDTH-1:0] acc,
                                                input logic n, input logic hi);
      return neg_if(n, hi ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0]);
   endfunction

   logic               s1, s2, a_neg, b_neg, div0, ovf;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     msum, dtrial;
   logic [2*WIDTH-1:0] mul_nx, div_nx;

   always_comb begin
      s1     = i_func3[2] ? ~i_func3[0] : ~(i_func3[1] & i_func3[0]);
      s2     = i_func3[2] ? ~i_func3[0] : ~i_func3[1];
      a_neg  = s1 & i_rs1[WIDTH-1];
      b_neg  = s2 & i_rs2[WIDTH-1];
      a_mag  = neg_if(a_neg, i_rs1);
      b_mag  = neg_if(b_neg, i_rs2);
      div0   = (i_rs2 == '0);
      ovf    = s1 & (i_rs1 == MOST_NEG) & (i_rs2 == '1);
      msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      mul_nx = {msum, acc_q[WIDTH-1:1]};
      dtrial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
      div_nx = dtrial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                             : {dtrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      fast_d   = fast_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
      unique case (state_q)
         S_IDLE, S_FIN: begin
            state_d = S_IDLE;
            if (i_start && !i_flush) begin
               busy_d = 1'b1;
               cnt_d  = '0;
               if (!i_func3[2]) begin
                  state_d = S_MUL;
                  acc_d   = {{WIDTH{1'b0}}, b_mag};
                  b_d     = a_mag;
                  neg_d   = a_neg ^ b_neg;
                  hi_d    = (i_func3[1:0] != 2'b00);
                  fast_d  = 1'b0;
               end else begin
                  state_d = S_DIV;
                  b_d     = b_mag;
                  neg_d   = i_func3[1] ? a_neg : (a_neg ^ b_neg);
                  hi_d    = i_func3[1];
                  fast_d  = div0 | ovf;
                  // Special cases park the final result in the low half.
                  if (div0)
                     acc_d = {{WIDTH{1'b0}}, (i_func3[1] ? i_rs1 : {WIDTH{1'b1}})};
                  else if (ovf)
                     acc_d = {{WIDTH{1'b0}}, (i_func3[1] ? {WIDTH{1'b0}} : i_rs1)};
                  else
                     acc_d = {{WIDTH{1'b0}}, a_mag};
               end
            end
         end
         S_MUL, S_DIV: begin
            if (i_flush) begin
               state_d = S_IDLE;
            end else if (state_q == S_DIV && fast_q) begin
               state_d  = S_FIN;
               done_d   = 1'b1;
               result_d = acc_q[WIDTH-1:0];
            end else begin
               acc_d  = (state_q == S_MUL) ? mul_nx : div_nx;
               cnt_d  = cnt_q + CW'(1);
               busy_d = 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_d  = S_FIN;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  result_d = (state_q == S_MUL) ? mul_fix(mul_nx, neg_q, hi_q)
                                                : div_fix(div_nx, neg_q, hi_q);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         hi_q     <= 1'b0;
         fast_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         fast_q   <= fast_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign o_busy   = busy_q;
   assign o_done   = done_q;
   assign o_result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and randomized bench for mdu_iter (WIDTH=32) with a queue scoreboard
// of expected results and a 64-bit arithmetic reference model.
module tb_mdu_iter;

   logic        clk;
   logic        rst;
   logic        i_start;
   logic [2:0]  i_func3;
   logic [31:0] i_rs1;
   logic [31:0] i_rs2;
   logic        i_flush;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_result;

   int tests = 0;
   int fails = 0;
   logic [31:0] sb[$];

   mdu_iter #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_start  (i_start),
      .i_func3  (i_func3),
      .i_rs1    (i_rs1),
      .i_rs2    (i_rs2),
      .i_flush  (i_flush),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_result (o_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      longint     sa, sb_, ub;
      logic [63:0] p, up;
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      ub  = longint'({32'd0, b});
      up  = {32'd0, a} * {32'd0, b};
      case (f)
         3'd0: begin p = sa * sb_; return p[31:0]; end
         3'd1: begin p = sa * sb_; return p[63:32]; end
         3'd2: begin p = sa * ub;  return p[63:32]; end
         3'd3: return up[63:32];
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb_; return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb_; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Drives a request for one edge (the accepting edge), then scrambles the inputs.
   task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      i_start = 1'b1;
      i_func3 = f;
      i_rs1   = a;
      i_rs2   = b;
      @(posedge clk); #1;
      i_start = 1'b0;
      i_func3 = 3'($urandom);
      i_rs1   = $urandom;
      i_rs2   = $urandom;
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int lat = 0;
      int bcnt = 0;
      logic [31:0] exp;
      while (!o_done && lat < 100) begin
         if (o_busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " busy cycles"}, 32'(bcnt), 32'(exp_lat));
      if (sb.size() == 0) begin
         check({tag, " scoreboard empty"}, 32'(sb.size()), 32'd1);
      end else begin
         exp = sb.pop_front();
         check({tag, " result"}, o_result, exp);
      end
   endtask

   task automatic check_pulse_end(input string tag);
      logic [31:0] held;
      held = o_result;
      @(posedge clk); #1;
      check({tag, " done drops"}, {31'd0, o_done}, 32'd0);
      check({tag, " result held"}, o_result, held);
   endtask

   initial begin
      logic [31:0] saved;
      logic        seen_done;
      logic [2:0]  f;
      logic [31:0] a, b;
      int          lat;

      rst = 1'b0; i_start = 1'b0; i_func3 = '0; i_rs1 = '0; i_rs2 = '0; i_flush = 1'b0;
      #1;
      check("reset busy", {31'd0, o_busy}, 32'd0);
      check("reset done", {31'd0, o_done}, 32'd0);
      check("reset result", o_result, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      sb.push_back(32'hFFFF_FFEB);
      start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
      wait_done("MUL 7*-3", 32);
      check_pulse_end("MUL 7*-3");

      sb.push_back(32'h4000_0000);
      start_op(3'd1, 32'h8000_0000, 32'h8000_0000);
      wait_done("MULH min*min", 32);
      sb.push_back(32'hFFFF_FFFE);
      start_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("MULHU max*max", 32);
      sb.push_back(32'hFFFF_FFFF);
      start_op(3'd2, 32'hFFFF_FFFF, 32'd2);
      wait_done("MULHSU -1*2", 32);

      sb.push_back(32'hFFFF_FFFD);
      start_op(3'd4, 32'hFFFF_FFF9, 32'd2);
      wait_done("DIV -7/2", 32);
      sb.push_back(32'hFFFF_FFFF);
      start_op(3'd6, 32'hFFFF_FFF9, 32'd2);
      wait_done("REM -7/2", 32);
      sb.push_back(32'd14);
      start_op(3'd5, 32'd100, 32'd7);
      wait_done("DIVU 100/7 back-to-back", 32);
      check_pulse_end("DIVU 100/7");

      sb.push_back(32'hFFFF_FFFF);
      start_op(3'd5, 32'd5, 32'd0);
      wait_done("DIVU 5/0", 1);
      sb.push_back(32'd5);
      start_op(3'd7, 32'd5, 32'd0);
      wait_done("REMU 5/0", 1);
      sb.push_back(32'h8000_0000);
      start_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("DIV overflow", 1);
      sb.push_back(32'd0);
      start_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("REM overflow", 1);
      check_pulse_end("REM overflow");

      // A start pulsed mid-operation must be ignored.
      sb.push_back(ref_op(3'd0, 32'd12345, 32'd678));
      start_op(3'd0, 32'd12345, 32'd678);
      repeat (9) begin @(posedge clk); #1; end
      i_start = 1'b1; i_func3 = 3'd5; i_rs1 = 32'd99; i_rs2 = 32'd3;
      @(posedge clk); #1;
      i_start = 1'b0;
      wait_done("MUL ignore start", 22);
      check_pulse_end("MUL ignore start");

      // Flush at edge 15 of a MUL: no completion, result untouched.
      saved = o_result;
      start_op(3'd0, 32'd3, 32'd5);
      repeat (14) begin @(posedge clk); #1; end
      i_flush = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0;
      check("flush busy", {31'd0, o_busy}, 32'd0);
      seen_done = 1'b0;
      repeat (40) begin
         if (o_done) seen_done = 1'b1;
         @(posedge clk); #1;
      end
      check("flush no done", {31'd0, seen_done}, 32'd0);
      check("flush result", o_result, saved);

      // Flush beats a simultaneous start while idle.
      i_flush = 1'b1;
      start_op(3'd5, 32'd10, 32'd2);
      i_flush = 1'b0;
      check("flush vs start busy", {31'd0, o_busy}, 32'd0);

      // Asynchronous reset in the middle of a DIV.
      start_op(3'd4, 32'd1000, 32'd7);
      repeat (19) begin @(posedge clk); #1; end
      #2 rst = 1'b0;
      #1;
      check("async rst busy", {31'd0, o_busy}, 32'd0);
      check("async rst done", {31'd0, o_done}, 32'd0);
      check("async rst result", o_result, 32'd0);
      seen_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (o_done) seen_done = 1'b1;
      end
      check("rst no done", {31'd0, seen_done}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      sb.push_back(32'd142);
      start_op(3'd4, 32'd1000, 32'd7);
      wait_done("DIV after reset", 32);

      for (int i = 0; i < 8; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         lat = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 32;
         sb.push_back(ref_op(f, a, b));
         start_op(f, a, b);
         wait_done($sformatf("rand f%0d %0h/%0h", f, a, b), lat);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
